// File: rtl/bip_pkg.sv
// -----------------------------------------------------------------------------
// bip_pkg
// Shared definitions for the BIP fetch/decode control unit: default widths,
// opcode values, accumulator/ALU source encodings, ALU op encodings and the
// control FSM state codes.
// -----------------------------------------------------------------------------
package bip_pkg;

  // Default widths
  localparam int LEN_ADDR   = 11;
  localparam int LEN_DATA   = 16;
  localparam int LEN_OPCODE = 5;
  localparam int LEN_COUNT  = 16;

  // Opcodes (instr[15:11])
  localparam logic [LEN_OPCODE-1:0] OPC_HLT  = 5'b00000;
  localparam logic [LEN_OPCODE-1:0] OPC_STO  = 5'b00001;
  localparam logic [LEN_OPCODE-1:0] OPC_LD   = 5'b00010;
  localparam logic [LEN_OPCODE-1:0] OPC_LDI  = 5'b00011;
  localparam logic [LEN_OPCODE-1:0] OPC_ADD  = 5'b00100;
  localparam logic [LEN_OPCODE-1:0] OPC_ADDI = 5'b00101;
  localparam logic [LEN_OPCODE-1:0] OPC_SUB  = 5'b00110;
  localparam logic [LEN_OPCODE-1:0] OPC_SUBI = 5'b00111;

  // Accumulator source select
  localparam logic [1:0] SEL_A_MEM = 2'd0;
  localparam logic [1:0] SEL_A_IMM = 2'd1;
  localparam logic [1:0] SEL_A_ALU = 2'd2;

  // ALU B source select
  localparam logic SEL_B_MEM = 1'b0;
  localparam logic SEL_B_IMM = 1'b1;

  // ALU operation
  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_SUB = 1'b1;

  // Control FSM states
  localparam logic [1:0] ST_FILL = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

endpackage

// File: rtl/bip_decoder.sv
// -----------------------------------------------------------------------------
// bip_decoder
// Purely combinational opcode decoder. Outputs are the raw decode of the
// opcode; the caller gates them with FSM state and enable.
// Ports:
//   i_opcode  opcode field of the instruction word
//   o_wr_acc  accumulator write enable
//   o_sel_a   accumulator source (memory / immediate / ALU)
//   o_sel_b   ALU B source (memory / immediate)
//   o_op      ALU operation (add / sub)
//   o_wr_ram  data memory write
//   o_rd_ram  data memory read
//   o_is_hlt  instruction is HLT
// -----------------------------------------------------------------------------
module bip_decoder
  import bip_pkg::*;
#(
  parameter int len_opcode = LEN_OPCODE
) (
  input  logic [len_opcode-1:0] i_opcode,
  output logic                  o_wr_acc,
  output logic [1:0]            o_sel_a,
  output logic                  o_sel_b,
  output logic                  o_op,
  output logic                  o_wr_ram,
  output logic                  o_rd_ram,
  output logic                  o_is_hlt
);

  always_comb begin
    o_wr_acc = 1'b0;
    o_sel_a  = SEL_A_MEM;
    o_sel_b  = SEL_B_MEM;
    o_op     = ALU_ADD;
    o_wr_ram = 1'b0;
    o_rd_ram = 1'b0;
    o_is_hlt = 1'b0;
    case (i_opcode)
      OPC_HLT: o_is_hlt = 1'b1;
      OPC_STO: o_wr_ram = 1'b1;
      OPC_LD: begin
        o_rd_ram = 1'b1;
        o_wr_acc = 1'b1;
        o_sel_a  = SEL_A_MEM;
      end
      OPC_LDI: begin
        o_wr_acc = 1'b1;
        o_sel_a  = SEL_A_IMM;
      end
      OPC_ADD: begin
        o_rd_ram = 1'b1;
        o_wr_acc = 1'b1;
        o_sel_a  = SEL_A_ALU;
        o_sel_b  = SEL_B_MEM;
        o_op     = ALU_ADD;
      end
      OPC_ADDI: begin
        o_wr_acc = 1'b1;
        o_sel_a  = SEL_A_ALU;
        o_sel_b  = SEL_B_IMM;
        o_op     = ALU_ADD;
      end
      OPC_SUB: begin
        o_rd_ram = 1'b1;
        o_wr_acc = 1'b1;
        o_sel_a  = SEL_A_ALU;
        o_sel_b  = SEL_B_MEM;
        o_op     = ALU_SUB;
      end
      OPC_SUBI: begin
        o_wr_acc = 1'b1;
        o_sel_a  = SEL_A_ALU;
        o_sel_b  = SEL_B_IMM;
        o_op     = ALU_SUB;
      end
      default: ; // unassigned opcodes execute as NOP
    endcase
  end

endmodule

// File: rtl/bip_control.sv
// -----------------------------------------------------------------------------
// bip_control
// Fetch/decode control unit of the BIP processor. Owns the program counter,
// drives the program memory address and decodes the word memory returns one
// cycle later. Halts on HLT and counts committed instructions.
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-high reset
//   enable       commit permission; low stalls the unit
//   instr        instruction word from program memory (registered read)
//   addr         program memory address
//   operand      instr[len_addr-1:0], raw
//   wr_acc       accumulator write enable
//   sel_a        accumulator source select
//   sel_b        ALU B source select
//   op           ALU operation
//   wr_ram       data memory write
//   rd_ram       data memory read
//   halt         processor halted
//   instr_count  committed instruction count (saturating)
// -----------------------------------------------------------------------------
module bip_control
  import bip_pkg::*;
#(
  parameter int len_addr   = LEN_ADDR,
  parameter int len_data   = LEN_DATA,
  parameter int len_opcode = LEN_OPCODE,
  parameter int len_count  = LEN_COUNT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [len_data-1:0]  instr,
  output logic [len_addr-1:0]  addr,
  output logic [len_addr-1:0]  operand,
  output logic                 wr_acc,
  output logic [1:0]           sel_a,
  output logic                 sel_b,
  output logic                 op,
  output logic                 wr_ram,
  output logic                 rd_ram,
  output logic                 halt,
  output logic [len_count-1:0] instr_count
);

  logic [1:0]           r_state;
  logic [len_addr-1:0]  r_pc;      // next fetch address
  logic [len_addr-1:0]  r_pc_dec;  // address of the word currently on instr
  logic [len_count-1:0] r_count;

  logic                 w_commit;
  logic                 w_dec_wr_acc;
  logic [1:0]           w_dec_sel_a;
  logic                 w_dec_sel_b;
  logic                 w_dec_op;
  logic                 w_dec_wr_ram;
  logic                 w_dec_rd_ram;
  logic                 w_dec_is_hlt;

  bip_decoder #(
    .len_opcode (len_opcode)
  ) u_dec (
    .i_opcode (instr[len_data-1 -: len_opcode]),
    .o_wr_acc (w_dec_wr_acc),
    .o_sel_a  (w_dec_sel_a),
    .o_sel_b  (w_dec_sel_b),
    .o_op     (w_dec_op),
    .o_wr_ram (w_dec_wr_ram),
    .o_rd_ram (w_dec_rd_ram),
    .o_is_hlt (w_dec_is_hlt)
  );

  // The word on instr is valid and allowed to commit this cycle.
  assign w_commit = (r_state == ST_RUN) && enable;

  assign wr_acc = w_commit & w_dec_wr_acc;
  assign sel_a  = w_commit ? w_dec_sel_a : 2'b00;
  assign sel_b  = w_commit & w_dec_sel_b;
  assign op     = w_commit & w_dec_op;
  assign wr_ram = w_commit & w_dec_wr_ram;
  assign rd_ram = w_commit & w_dec_rd_ram;

  // When not advancing, re-present pc_dec so memory keeps returning the
  // word that is waiting to commit (stall) or the HLT word (halted).
  assign addr = ((r_state == ST_FILL) || w_commit) ? r_pc : r_pc_dec;

  assign operand     = instr[len_addr-1:0];
  assign halt        = (r_state == ST_HALT);
  assign instr_count = r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_FILL;
      r_pc     <= '0;
      r_pc_dec <= '0;
      r_count  <= '0;
    end else begin
      case (r_state)
        ST_FILL: begin
          // Memory output is not yet valid; just start the pipeline.
          r_state  <= ST_RUN;
          r_pc_dec <= r_pc;
          r_pc     <= r_pc + 1'b1;
        end
        ST_RUN: begin
          if (enable) begin
            if (r_count != {len_count{1'b1}}) begin
              r_count <= r_count + 1'b1;
            end
            if (w_dec_is_hlt) begin
              r_state <= ST_HALT;
            end else begin
              r_pc_dec <= r_pc;
              r_pc     <= r_pc + 1'b1;  // wraps silently at the top
            end
          end
        end
        default: ; // HALT (and the unused code) hold until reset
      endcase
    end
  end

endmodule

// File: tb/tb_bip_control.sv
module tb_bip_control;
  import bip_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic [15:0] mem [2048];
  logic [15:0] instr_a = '0;
  logic [15:0] instr_b = '0;

  logic [10:0] addr_a, operand_a, addr_b, operand_b;
  logic        wr_acc_a, sel_b_a, op_a, wr_ram_a, rd_ram_a, halt_a;
  logic        wr_acc_b, sel_b_b, op_b, wr_ram_b, rd_ram_b, halt_b;
  logic [1:0]  sel_a_a, sel_a_b;
  logic [15:0] count_a;
  logic [3:0]  count_b;
  logic [6:0]  ctrl_a, ctrl_b;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [4:0] opc;
    logic [6:0] exp_ctrl;  // {wr_acc, sel_a, sel_b, op, wr_ram, rd_ram}
    string      name;
  } vec_t;
  vec_t vecs [8];

  always #5 clk = ~clk;

  // Registered-address program memory, one read port per DUT
  always @(posedge clk) begin
    instr_a <= mem[addr_a];
    instr_b <= mem[addr_b];
  end

  assign ctrl_a = {wr_acc_a, sel_a_a, sel_b_a, op_a, wr_ram_a, rd_ram_a};
  assign ctrl_b = {wr_acc_b, sel_a_b, sel_b_b, op_b, wr_ram_b, rd_ram_b};

  bip_control dut_a (
    .clk(clk), .reset(reset), .enable(enable), .instr(instr_a),
    .addr(addr_a), .operand(operand_a), .wr_acc(wr_acc_a), .sel_a(sel_a_a),
    .sel_b(sel_b_a), .op(op_a), .wr_ram(wr_ram_a), .rd_ram(rd_ram_a),
    .halt(halt_a), .instr_count(count_a)
  );

  bip_control #(.len_count(4)) dut_b (
    .clk(clk), .reset(reset), .enable(enable), .instr(instr_b),
    .addr(addr_b), .operand(operand_b), .wr_acc(wr_acc_b), .sel_a(sel_a_b),
    .sel_b(sel_b_b), .op(op_b), .wr_ram(wr_ram_b), .rd_ram(rd_ram_b),
    .halt(halt_b), .instr_count(count_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] mk(input logic [4:0] o, input logic [10:0] opd);
    return {o, opd};
  endfunction

  // All NOPs whose operand equals their own address
  task automatic clear_mem();
    for (int i = 0; i < 2048; i++) mem[i] = mk(5'b01000, i[10:0]);
  endtask

  // Leaves the DUTs in FILL, 1 time unit after reset release
  task automatic do_reset();
    reset = 1'b1;
    enable = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  initial begin
    vecs[0] = '{5'b00001, 7'b0000010, "STO"};
    vecs[1] = '{5'b00010, 7'b1000001, "LD"};
    vecs[2] = '{5'b00011, 7'b1010000, "LDI"};
    vecs[3] = '{5'b00100, 7'b1100001, "ADD"};
    vecs[4] = '{5'b00101, 7'b1101000, "ADDI"};
    vecs[5] = '{5'b00110, 7'b1100101, "SUB"};
    vecs[6] = '{5'b00111, 7'b1101100, "SUBI"};
    vecs[7] = '{5'b11111, 7'b0000000, "NOP31"};

    // ---------------- program {LDI 5, ADDI 3, STO 2, HLT}
    clear_mem();
    mem[0] = mk(5'b00011, 11'd5);
    mem[1] = mk(5'b00101, 11'd3);
    mem[2] = mk(5'b00001, 11'd2);
    mem[3] = mk(5'b00000, 11'd0);
    mem[4] = mk(5'b00011, 11'd7);
    do_reset();
    check("reset_addr", 32'(addr_a), 32'd0);
    check("reset_halt", 32'(halt_a), 32'd0);
    check("reset_count", 32'(count_a), 32'd0);
    check("reset_ctrl", 32'(ctrl_a), 32'd0);
    @(posedge clk); #1;
    check("p1_ldi_addr", 32'(addr_a), 32'd1);
    check("p1_ldi_ctrl", 32'(ctrl_a), 32'b1010000);
    check("p1_ldi_operand", 32'(operand_a), 32'd5);
    @(posedge clk); #1;
    check("p1_addi_addr", 32'(addr_a), 32'd2);
    check("p1_addi_ctrl", 32'(ctrl_a), 32'b1101000);
    @(posedge clk); #1;
    check("p1_sto_addr", 32'(addr_a), 32'd3);
    check("p1_sto_ctrl", 32'(ctrl_a), 32'b0000010);
    check("p1_sto_count", 32'(count_a), 32'd2);
    @(posedge clk); #1;
    check("p1_hlt_ctrl", 32'(ctrl_a), 32'd0);
    check("p1_hlt_halt_pre", 32'(halt_a), 32'd0);
    check("p1_hlt_count_pre", 32'(count_a), 32'd3);
    @(posedge clk); #1;
    check("p1_halt", 32'(halt_a), 32'd1);
    check("p1_halt_count", 32'(count_a), 32'd4);
    check("p1_halt_addr", 32'(addr_a), 32'd3);
    check("p1_halt_ctrl", 32'(ctrl_a), 32'd0);
    @(posedge clk); #1;
    check("p1_halt_addr_hold", 32'(addr_a), 32'd3);
    check("p1_halt_count_hold", 32'(count_a), 32'd4);

    // ---------------- opcode table
    clear_mem();
    for (int i = 0; i < 8; i++) mem[i] = mk(vecs[i].opc, 11'(i + 16));
    mem[8] = mk(5'b00000, 11'd0);
    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      check({"tbl_ctrl_", vecs[i].name}, 32'(ctrl_a), 32'(vecs[i].exp_ctrl));
      check({"tbl_operand_", vecs[i].name}, 32'(operand_a), 32'(i + 16));
      check({"tbl_count_", vecs[i].name}, 32'(count_a), 32'(i));
      check({"tbl_addr_", vecs[i].name}, 32'(addr_a), 32'(i + 1));
    end
    @(posedge clk); #1;
    check("tbl_count_end", 32'(count_a), 32'd8);

    // ---------------- stall while ADD at 6 is decoding
    clear_mem();
    mem[6] = mk(5'b00100, 11'd9);
    do_reset();
    repeat (7) @(posedge clk);
    #1;
    enable = 1'b0;
    #1;
    for (int s = 0; s < 3; s++) begin
      if (s > 0) begin
        @(posedge clk); #1;
      end
      check("stall_ctrl", 32'(ctrl_a), 32'd0);
      check("stall_addr", 32'(addr_a), 32'd6);
      check("stall_count", 32'(count_a), 32'd6);
      check("stall_operand", 32'(operand_a), 32'd9);
    end
    enable = 1'b1;
    #1;
    check("resume_ctrl", 32'(ctrl_a), 32'b1100001);
    check("resume_addr", 32'(addr_a), 32'd7);
    @(posedge clk); #1;
    check("resume_count", 32'(count_a), 32'd7);
    check("resume_next_addr", 32'(addr_a), 32'd8);
    check("resume_next_ctrl", 32'(ctrl_a), 32'd0);

    // ---------------- reset mid-run at pc=9
    clear_mem();
    mem[8] = mk(5'b00011, 11'd8);
    do_reset();
    repeat (9) @(posedge clk);
    #1;
    check("mid_addr_pre", 32'(addr_a), 32'd9);
    check("mid_ctrl_pre", 32'(ctrl_a), 32'b1010000);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_addr", 32'(addr_a), 32'd0);
    check("mid_rst_ctrl", 32'(ctrl_a), 32'd0);
    check("mid_rst_count", 32'(count_a), 32'd0);
    check("mid_rst_halt", 32'(halt_a), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("mid_fill_addr", 32'(addr_a), 32'd0);
    @(posedge clk); #1;
    check("mid_first_decode", 32'(operand_a), 32'd0);
    check("mid_first_addr", 32'(addr_a), 32'd1);

    // ---------------- pc wrap (2048 fetches) and 4-bit count saturation
    clear_mem();
    do_reset();
    for (int k = 1; k <= 2050; k++) begin
      @(posedge clk); #1;
      check("wrap_addr", 32'(addr_a), 32'(k % 2048));
      check("wrap_addr_b", 32'(addr_b), 32'(k % 2048));
      check("wrap_operand", 32'(operand_a), 32'((k - 1) % 2048));
      check("wrap_operand_b", 32'(operand_b), 32'((k - 1) % 2048));
      check("wrap_ctrl", 32'({ctrl_a, ctrl_b, halt_a, halt_b}), 32'd0);
      if (k == 15) check("sat_count_14", 32'(count_b), 32'd14);
      if (k == 16) check("sat_count_15", 32'(count_b), 32'd15);
      if (k == 17) check("sat_count_hold", 32'(count_b), 32'd15);
    end
    check("sat_count_end", 32'(count_b), 32'd15);
    check("wrap_count_a", 32'(count_a), 32'd2049);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
